slice_compare_seq: RTL
======================

Name: slice_compare_seq

Overview:
- Sequential magnitude comparator for WIDTH-bit unsigned operands.
- Reuses one 2-bit cascadable compare slice over multiple cycles, MSB pair first.
- Slice cascade inputs are eqIn ("equal so far") and gtIn ("already greater"). Slice cascade outputs are eqOut and gtOut.
- Used where a full-width parallel comparator is too costly. Sits between a requesting master and the shared slice logic.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2; odd values are a compile-time error.
- NSLICE, WIDTH/2, number of 2-bit slices. Derived value; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepted start edge.
- b  input  WIDTH  operand B. Captured on the accepted start edge.
- busy  output  1  high while slices are being evaluated (RUN).
- done  output  1  single-cycle pulse: result is valid.
- eq  output  1  result: A == B.
- gt  output  1  result: A > B. lt is implied by eq=0 and gt=0.
- slices_used  output  $clog2(NSLICE+1)  number of slices evaluated for the last result.

Behaviour:
- Reset, synchronous, active-high. On any edge with rst=1:
  - state=IDLE.
  - busy=0, done=0, eq=0, gt=0, slices_used=0.
  - Captured operands and slice index cleared.
- Reset mid-operation aborts the current comparison. No done pulse is produced and results read 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, capture a and b into operand registers.
  - Set accumulators eq_acc=1, gt_acc=0. Set idx=NSLICE-1 and slices_used=0.
  - Go to RUN. busy=1 from that edge.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Evaluate slice idx on bits [2*idx+1:2*idx] of both operands.
  - eq_next = eq_acc & (a_pair == b_pair).
  - gt_next = gt_acc | (eq_acc & (a_pair > b_pair)).
  - Store eq_next/gt_next into the accumulators. slices_used += 1.
  - Terminate if idx==0, otherwise idx -= 1 and stay in RUN. (Early termination: see Optional Feature.)
  - On termination: copy eq_next/gt_next to eq/gt, go to DONE, busy=0.
- DONE:
  - done=1 for exactly this one cycle. Next edge returns to IDLE.
  - start is ignored in DONE.
- Result hold: eq, gt and slices_used hold until the next accepted start. At the accepted start they are cleared to 0.
- Invariant: eq and gt are never both 1.
- Latency without early exit: done rises NSLICE+1 edges after the edge that accepted start (WIDTH=8: 5 edges).
- start while busy or in DONE: ignored. No queueing and no effect on the in-flight result.
- Operand inputs may change freely after the accept edge; only the captured copies are used.
- Back-to-back operation: the earliest next accept is the edge after DONE, i.e. one IDLE cycle minimum between requests.

Optional Feature:
- Macro: SLICE_COMPARE_SEQ_EARLY_EXIT_EN.
- Defined:
  - RUN also terminates on the first edge where eq_next=0. The lower slices cannot change the result once inequality is found.
  - slices_used reports the actual count (1..NSLICE).
  - Latency becomes slices_used+1 edges.
- Undefined:
  - All NSLICE slices are always evaluated. Latency is fixed at NSLICE+1 edges and slices_used = NSLICE.
  - Results are identical in both builds; only timing and slices_used differ.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start 1 cycle:
  - busy high 4 cycles; done pulses on the 5th edge; eq=1, gt=0, slices_used=4. Same result in both builds.
- a=0xC0, b=0x80:
  - With the macro: done on the 2nd edge, gt=1, eq=0, slices_used=1.
  - Without the macro: done on the 5th edge, gt=1, slices_used=4.
- a=0x12, b=0x13:
  - eq=0, gt=0 (A<B), done on the 5th edge, slices_used=4 in both builds (the difference is in the last slice).
- start pulsed again, with different operands, while busy (a=0x01, b=0x00 into a 0xFF/0xFF run):
  - Ignored. Result is eq=1, gt=0. No second done pulse.
- rst=1 asserted on the 2nd RUN edge of a 0xFF vs 0x00 compare:
  - Next cycle: busy=0, done=0, eq=0, gt=0. No done pulse follows.
  - A fresh start then completes normally.
- Back-to-back: start again in the IDLE cycle after DONE with a=0x00, b=0xFF:
  - Accepted. eq/gt clear at accept; final eq=0, gt=0.

Source files
------------

// File: rtl/slice_compare_seq.sv
`default_nettype none
// ============================================================================
// Module   : slice_compare_seq
// Purpose  : Sequential unsigned magnitude comparator. One 2-bit cascadable
//            compare slice is reused once per cycle, MSB pair first. The
//            slice's cascade inputs are eqIn ("equal so far") and gtIn
//            ("already greater"), and its outputs are eqOut/gtOut.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH        operand width in bits (even, >= 2)
// Ports:
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous reset, active-high
//   start        in   1              request pulse, sampled only in IDLE
//   a, b         in   WIDTH          operands, captured on the accept edge
//   busy         out  1              high while slices are evaluated (RUN)
//   done         out  1              one-cycle pulse, result valid
//   eq           out  1              result A == B
//   gt           out  1              result A > B (lt = !eq & !gt)
//   slices_used  out  clog2(NSLICE+1) slices evaluated for the last result
// Build option:
//   SLICE_COMPARE_SEQ_EARLY_EXIT_EN - when defined, RUN stops on the first
//   unequal slice; otherwise all NSLICE slices are always evaluated.
// ============================================================================
module slice_compare_seq #(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  output logic                               busy,
  output logic                               done,
  output logic                               eq,
  output logic                               gt,
  output logic [$clog2((WIDTH/2)+1)-1:0]     slices_used
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SUW    = $clog2(NSLICE + 1);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  // Odd or too-small widths cannot be split into 2-bit pairs.
  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
    $error("slice_compare_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  idx_q;
  logic             eq_acc_q, gt_acc_q;
  logic             busy_q, done_q, eq_q, gt_q;
  logic [SUW-1:0]   slices_used_q;

  // Shared 2-bit slice: cascade in from the accumulators, cascade out to _d.
  logic [1:0] pair_a, pair_b;
  logic       eq_d, gt_d;
  logic       term_d;

  always_comb begin
    pair_a = a_q[{idx_q, 1'b0} +: 2];
    pair_b = b_q[{idx_q, 1'b0} +: 2];
    eq_d   = eq_acc_q & (pair_a == pair_b);
    // Greater only counts if all higher pairs were equal.
    gt_d   = gt_acc_q | (eq_acc_q & (pair_a > pair_b));
`ifdef SLICE_COMPARE_SEQ_EARLY_EXIT_EN
    // Once a pair differs the lower pairs cannot change the outcome.
    term_d = (idx_q == '0) | ~eq_d;
`else
    term_d = (idx_q == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      idx_q         <= '0;
      eq_acc_q      <= 1'b0;
      gt_acc_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      eq_q          <= 1'b0;
      gt_q          <= 1'b0;
      slices_used_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q           <= a;
            b_q           <= b;
            eq_acc_q      <= 1'b1;
            gt_acc_q      <= 1'b0;
            idx_q         <= IDX_TOP;
            slices_used_q <= '0;
            eq_q          <= 1'b0;
            gt_q          <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_RUN;
          end
        end
        S_RUN: begin
          eq_acc_q      <= eq_d;
          gt_acc_q      <= gt_d;
          slices_used_q <= slices_used_q + SUW'(1);
          if (term_d) begin
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign eq          = eq_q;
  assign gt          = gt_q;
  assign slices_used = slices_used_q;

endmodule
`default_nettype wire
